reg_write_arbiter: RTL and testbench

- Round-robin write-port arbiter/sequencer for a bank of 2**ADDR_WIDTH simple registers.
- Accepts write requests (address + data) from NUM_REQ requesters (e.g. ALU writeback, load unit, link/PC save).
- Grants one request at a time and drives the bank's per-register enable lines and a shared data bus.
- Sits between pipeline writeback sources and the register bank; one write per grant, no data buffering.

---
 rtl/reg_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_reg_write_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for a register bank: picks one requester at a
// time and drives a one-cycle one-hot register enable plus the write data.
module reg_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hold,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [(2**ADDR_WIDTH)-1:0]     reg_enable,
  output logic [DATA_WIDTH-1:0]          reg_data,
  output logic                           busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t                  state_q;
  logic [PTR_W-1:0]        rr_ptr_q;
  logic [PTR_W-1:0]        rr_ptr_d;
  logic [PTR_W-1:0]        win_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [NUM_REGS-1:0]     reg_enable_q;
  logic [DATA_WIDTH-1:0]   reg_data_q;
  logic                    busy_q;

  logic                    win_found_s;
  logic [PTR_W-1:0]        win_idx_s;
  logic [ADDR_WIDTH-1:0]   win_addr_s;
  logic [DATA_WIDTH-1:0]   win_data_s;

  // Wrap-around increment of a requester index
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) begin
      next_idx = '0;
    end else begin
      next_idx = idx + 1'b1;
    end
  endfunction

  // First set request bit at or above rr_ptr, wrapping around
  always_comb begin
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!win_found_s && req[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = PTR_W'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Address/data of the selected requester and the pointer after its grant
  always_comb begin
    win_addr_s = req_addr[int'(win_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
    win_data_s = req_data[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    rr_ptr_d   = next_idx(win_q);
  end

  // Sequencer FSM; outputs are registered so the enable pulse trails GRANT by one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      grant_q      <= '0;
      reg_enable_q <= '0;
      reg_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          grant_q      <= '0;
          reg_enable_q <= '0;
          reg_data_q   <= '0;
          if (!hold && win_found_s) begin
            win_q   <= win_idx_s;
            addr_q  <= win_addr_s;
            wdata_q <= win_data_s;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        GRANT: begin
          grant_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
          reg_enable_q <= {{(NUM_REGS-1){1'b0}}, 1'b1} << addr_q;
          reg_data_q   <= wdata_q;
          rr_ptr_q     <= rr_ptr_d;
          busy_q       <= 1'b1;
          state_q      <= RECOVER;
        end
        RECOVER: begin
          grant_q      <= '0;
          reg_enable_q <= '0;
          reg_data_q   <= '0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          grant_q      <= '0;
          reg_enable_q <= '0;
          reg_data_q   <= '0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign reg_enable = reg_enable_q;
  assign reg_data   = reg_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus random
// traffic, compared each cycle against a transaction-level reference model.
module tb_reg_write_arbiter;

  localparam int DW   = 32;
  localparam int NR   = 4;
  localparam int AW   = 3;
  localparam int NREG = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             hold;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    grant;
  logic [NREG-1:0]  reg_enable;
  logic [DW-1:0]    reg_data;
  logic             busy;

  reg_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .req(req), .req_addr(req_addr),
    .req_data(req_data), .grant(grant), .reg_enable(reg_enable),
    .reg_data(reg_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: m_age = edges since a request was accepted (-1 = idle)
  int              m_ptr;
  int              m_age;
  int              m_w;
  int              m_addr;
  logic [DW-1:0]   m_data;
  logic [NR-1:0]   exp_grant;
  logic [NREG-1:0] exp_en;
  logic [DW-1:0]   exp_data;
  logic            exp_busy;

  logic [NR-1:0]   g_q[$];
  logic [DW-1:0]   d_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_age = -1; m_w = 0; m_addr = 0; m_data = '0;
    exp_grant = '0; exp_en = '0; exp_data = '0; exp_busy = 1'b0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (m_age < 0) begin
      exp_grant = '0; exp_en = '0; exp_data = '0; exp_busy = 1'b0;
      if (!hold && (req != '0)) begin
        for (int k = 0; k < NR; k++) begin
          if (req[(m_ptr + k) % NR]) begin
            m_w = (m_ptr + k) % NR;
            break;
          end
        end
        m_addr   = int'(req_addr[m_w*AW +: AW]);
        m_data   = req_data[m_w*DW +: DW];
        m_age    = 0;
        exp_busy = 1'b1;
      end
    end else if (m_age == 0) begin
      exp_grant = NR'(1) << m_w;
      exp_en    = NREG'(1) << m_addr;
      exp_data  = m_data;
      exp_busy  = 1'b1;
      m_ptr     = (m_w + 1) % NR;
      m_age     = 1;
    end else begin
      exp_grant = '0; exp_en = '0; exp_data = '0; exp_busy = 1'b0;
      m_age     = -1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(exp_grant));
    chk({tag, "_en"}, 64'(reg_enable), 64'(exp_en));
    chk({tag, "_data"}, 64'(reg_data), 64'(exp_data));
    chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    if (grant != '0) begin
      g_q.push_back(grant);
      d_q.push_back(reg_data);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    cycle("rst_hold");
    reset = 1'b1;
    g_q.delete();
    d_q.delete();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0; req = '0; req_addr = '0; req_data = '0;
    model_reset();
    @(negedge clk);

    // 1: single write
    do_reset();
    set_req(1, 3'd5, 32'hDEADBEEF);
    req = 4'b0010;
    cycle("t1");
    req = 4'b0000;
    for (int c = 0; c < 6; c++) cycle("t1");
    chk("t1_ngrant", 64'(g_q.size()), 64'd1);
    if (g_q.size() == 1) chk("t1_grant_val", 64'(g_q[0]), 64'h2);

    // 2: round-robin with everything requesting
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, AW'(i), DW'(32'h100 + i));
    req = 4'b1111;
    for (int c = 0; c < 14; c++) cycle("t2");
    chk("t2_ngrant", 64'(g_q.size()), 64'd5);
    for (int i = 0; i < g_q.size() && i < 5; i++)
      chk("t2_order", 64'(g_q[i]), 64'(NR'(1) << (i % NR)));
    req = '0;

    // 3: pointer at 2 skips over to requester 0 first
    do_reset();
    req = 4'b0010;
    cycle("t3");
    req = 4'b0000;
    for (int c = 0; c < 3; c++) cycle("t3");
    g_q.delete();
    req = 4'b0011;
    for (int c = 0; c < 7; c++) cycle("t3");
    chk("t3_ngrant", 64'(g_q.size()), 64'd2);
    if (g_q.size() >= 2) begin
      chk("t3_first", 64'(g_q[0]), 64'h1);
      chk("t3_second", 64'(g_q[1]), 64'h2);
    end
    req = '0;

    // 4: hold blocks new grants
    do_reset();
    hold = 1'b1;
    req  = 4'b0100;
    for (int c = 0; c < 5; c++) cycle("t4");
    chk("t4_nogrant", 64'(g_q.size()), 64'd0);
    hold = 1'b0;
    cycle("t4");
    cycle("t4");
    chk("t4_grant", 64'(grant), 64'h4);
    req = '0;
    cycle("t4");

    // 5: asynchronous reset while the enable pulse is up
    do_reset();
    set_req(3, 3'd6, 32'h5555AAAA);
    req = 4'b1000;
    cycle("t5");
    cycle("t5");
    chk("t5_pre_grant", 64'(grant), 64'h8);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("t5_async");
    cycle("t5_rst");
    reset = 1'b1;
    g_q.delete();
    req = 4'b0110;
    cycle("t5");
    cycle("t5");
    chk("t5_after", 64'(grant), 64'h2);
    req = '0;
    cycle("t5");

    // 6: two requesters targeting the same register
    do_reset();
    set_req(0, 3'd3, 32'h1);
    set_req(2, 3'd3, 32'h2);
    req = 4'b0101;
    for (int c = 0; c < 6; c++) cycle("t6");
    req = '0;
    chk("t6_ngrant", 64'(d_q.size()), 64'd2);
    if (d_q.size() >= 2) begin
      chk("t6_first", 64'(d_q[0]), 64'h1);
      chk("t6_second", 64'(d_q[1]), 64'h2);
    end
    cycle("t6");

    // Random traffic, with occasional asynchronous resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req  = NR'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        req_addr = NR*AW'($urandom);
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rnd_async");
        cycle("rnd_rst");
        reset = 1'b1;
      end else begin
        cycle("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
